// File: rtl/d_e_register.sv
// Decode->Execute pipeline register: bubble insertion and Tnew ageing.
// Define DE_BUBBLE_STATS_EN to add bubble_cnt / stall_run counters.
module d_e_register #(
   parameter int TNEW_W    = 2,
   parameter int ALUCTRL_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 RegWriteD,
   input  logic [1:0]           MemtoRegD,
   input  logic                 MemWriteD,
   input  logic [ALUCTRL_W-1:0] ALUControlD,
   input  logic                 ALUSrcD,
   input  logic [1:0]           RegDstD,
   input  logic [31:0]          RD1D,
   input  logic [31:0]          RD2D,
   input  logic [4:0]           RsD,
   input  logic [4:0]           RtD,
   input  logic [4:0]           RdD,
   input  logic [31:0]          ext_immD,
   input  logic [31:0]          PC_4D,
   input  logic [TNEW_W-1:0]    TnewD,
   output logic                 RegWriteE,
   output logic [1:0]           MemtoRegE,
   output logic                 MemWriteE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic                 ALUSrcE,
   output logic [1:0]           RegDstE,
   output logic [31:0]          RD1E,
   output logic [31:0]          RD2E,
   output logic [4:0]           RsE,
   output logic [4:0]           RtE,
   output logic [4:0]           RdE,
   output logic [31:0]          ext_immE,
   output logic [31:0]          PC_4E,
   output logic [TNEW_W-1:0]    TnewE,
   output logic                 ValidE
`ifdef DE_BUBBLE_STATS_EN
   ,
   output logic [31:0]          bubble_cnt,
   output logic [7:0]           stall_run
`endif
);

   logic                 bubble;
   logic [TNEW_W-1:0]    tnew_aged;

   logic                 reg_write_d,   reg_write_q;
   logic [1:0]           memto_reg_d,   memto_reg_q;
   logic                 mem_write_d,   mem_write_q;
   logic [ALUCTRL_W-1:0] alu_ctrl_d,    alu_ctrl_q;
   logic                 alu_src_d,     alu_src_q;
   logic [1:0]           reg_dst_d,     reg_dst_q;
   logic [31:0]          rd1_d,         rd1_q;
   logic [31:0]          rd2_d,         rd2_q;
   logic [4:0]           rs_d,          rs_q;
   logic [4:0]           rt_d,          rt_q;
   logic [4:0]           rd_d,          rd_q;
   logic [31:0]          imm_d,         imm_q;
   logic [31:0]          pc4_d,         pc4_q;
   logic [TNEW_W-1:0]    tnew_d,        tnew_q;
   logic                 valid_d,       valid_q;

   assign bubble    = stall | flush;
   // Saturating age: a result already available stays at 0.
   assign tnew_aged = (TnewD == '0) ? '0
                                    : TnewD - TNEW_W'(1);

   always_comb begin
      reg_write_d = 1'b0;
      memto_reg_d = '0;
      mem_write_d = 1'b0;
      alu_ctrl_d  = '0;
      alu_src_d   = 1'b0;
      reg_dst_d   = '0;
      rd1_d       = '0;
      rd2_d       = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      imm_d       = '0;
      pc4_d       = '0;
      tnew_d      = '0;
      valid_d     = 1'b0;
      if (!bubble) begin
         reg_write_d = RegWriteD;
         memto_reg_d = MemtoRegD;
         mem_write_d = MemWriteD;
         alu_ctrl_d  = ALUControlD;
         alu_src_d   = ALUSrcD;
         reg_dst_d   = RegDstD;
         rd1_d       = RD1D;
         rd2_d       = RD2D;
         rs_d        = RsD;
         rt_d        = RtD;
         rd_d        = RdD;
         imm_d       = ext_immD;
         pc4_d       = PC_4D;
         tnew_d      = tnew_aged;
         valid_d     = 1'b1;
      end
   end

`ifdef DE_BUBBLE_STATS_EN
   logic [31:0] bubble_cnt_d, bubble_cnt_q;
   logic [7:0]  stall_run_d,  stall_run_q;

   assign bubble_cnt_d = bubble ? bubble_cnt_q + 32'd1
                                : bubble_cnt_q;
   assign stall_run_d  = !stall ? 8'd0 :
                         (stall_run_q == 8'hFF) ? 8'hFF
                                                : stall_run_q + 8'd1;
   assign bubble_cnt   = bubble_cnt_q;
   assign stall_run    = stall_run_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_q <= 1'b0;
         memto_reg_q <= '0;
         mem_write_q <= 1'b0;
         alu_ctrl_q  <= '0;
         alu_src_q   <= 1'b0;
         reg_dst_q   <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         pc4_q       <= '0;
         tnew_q      <= '0;
         valid_q     <= 1'b0;
`ifdef DE_BUBBLE_STATS_EN
         bubble_cnt_q <= '0;
         stall_run_q  <= '0;
`endif
      end else begin
         reg_write_q <= reg_write_d;
         memto_reg_q <= memto_reg_d;
         mem_write_q <= mem_write_d;
         alu_ctrl_q  <= alu_ctrl_d;
         alu_src_q   <= alu_src_d;
         reg_dst_q   <= reg_dst_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         pc4_q       <= pc4_d;
         tnew_q      <= tnew_d;
         valid_q     <= valid_d;
`ifdef DE_BUBBLE_STATS_EN
         bubble_cnt_q <= bubble_cnt_d;
         stall_run_q  <= stall_run_d;
`endif
      end
   end

   assign RegWriteE   = reg_write_q;
   assign MemtoRegE   = memto_reg_q;
   assign MemWriteE   = mem_write_q;
   assign ALUControlE = alu_ctrl_q;
   assign ALUSrcE     = alu_src_q;
   assign RegDstE     = reg_dst_q;
   assign RD1E        = rd1_q;
   assign RD2E        = rd2_q;
   assign RsE         = rs_q;
   assign RtE         = rt_q;
   assign RdE         = rd_q;
   assign ext_immE    = imm_q;
   assign PC_4E       = pc4_q;
   assign TnewE       = tnew_q;
   assign ValidE      = valid_q;

endmodule
